parity_frame_serializer: RTL and testbench
==========================================

Name: parity_frame_serializer

Overview:
- Sits directly downstream of the 4-bit even-parity generator.
- Accepts the generator's protected word {data, parity} through a valid/ready handshake and re-checks its parity.
- Transmits the word as a serial frame: one start bit (0), all word bits MSB first (parity bit last), then one stop bit (1), with each bit held for BAUD_DIV clocks.
- Feeds the board-level serial link in the parity lab chain.

Parameters:
- DATA_W, 4, payload data width; the protected word is DATA_W+1 bits wide, with parity in the LSB.
- BAUD_DIV, 4, clock cycles per serial bit; legal range 1..255.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DIN  input  DATA_W+1  protected word {data, parity} from the parity generator.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  serializer can accept a word this cycle.
- TXD  output  1  serial line output; idles high.
- BUSY  output  1  a frame is in progress (any state other than IDLE).
- PERR  output  1  one-cycle pulse when an accepted word fails even parity.

Behaviour:
- Reset is asynchronous, active-low, single clock domain. While RST_N=0, and immediately on assertion:
  - TXD=1, BUSY=0, PERR=0
  - state=IDLE; bit and baud counters =0; shift register =0
  - DIN_READY=1, since it is decoded from state==IDLE.
- Reset asserted mid-frame aborts the frame at once; TXD returns to 1 with no glitch to 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TXD=1, DIN_READY=1.
  - A transfer happens on a rising edge with DIN_VALID=1 and DIN_READY=1.
  - On a transfer, DIN is latched into the shift register and the next state is START.
  - DIN is sampled only on the transfer edge; later changes to DIN are ignored.
- START: TXD=0 for BAUD_DIV cycles, then DATA.
- DATA:
  - Outputs shift-register bit [DATA_W] down to bit [0]: DATA_W+1 bits, each for BAUD_DIV cycles.
  - Shifts left on each bit boundary; after the last bit, goes to STOP.
- STOP: TXD=1 for BAUD_DIV cycles, then IDLE.
- Timing:
  - Frame length is (DATA_W+3)*BAUD_DIV cycles from the first START cycle.
  - TXD is registered and changes 1 cycle after the accepting edge.
- Baud counter runs 0..BAUD_DIV-1 and wraps at each bit boundary. With BAUD_DIV=1, every bit lasts exactly one cycle.
- Back-to-back frames:
  - DIN_READY rises in the first IDLE cycle after STOP.
  - If DIN_VALID is held high, the next word is accepted on that edge. The minimum gap between frames is one idle cycle of TXD=1.
- Handshake rules:
  - DIN_READY=0 in START, DATA and STOP; DIN_VALID is ignored there, with no queuing.
  - DIN_VALID may drop before acceptance with no effect.
- Parity check:
  - On the accepting edge, compute XOR over all DATA_W+1 bits of DIN.
  - If the XOR is 1, PERR=1 for exactly the next cycle.
  - The word is still transmitted unchanged unless the optional feature is compiled in.
- BUSY=1 exactly while the state is not IDLE.

Optional Feature:
- Macro: PFS_DROP_BAD_EN.
- Defined:
  - A word failing parity is still accepted (handshake completes) and PERR still pulses.
  - State stays IDLE, TXD stays 1, and DIN_READY stays 1, so the next word can be accepted on the following edge.
- Undefined: bad words are transmitted like good ones; PERR is the only indication.

Test Plan:
- Reset then idle: hold RST_N=0 for 3 cycles, then release -> TXD=1, BUSY=0, DIN_READY=1, PERR=0.
- Good frame, DATA_W=4, BAUD_DIV=4, DIN=5'b10111 with VALID for 1 cycle:
  - TXD sequence 0,1,0,1,1,1,1, each held 4 cycles (28 cycles total).
  - PERR stays 0; BUSY high for 28 cycles.
- Bad parity, DIN=5'b10110:
  - PERR=1 for exactly one cycle after acceptance.
  - Without PFS_DROP_BAD_EN: TXD = 0,1,0,1,1,0,1.
  - With PFS_DROP_BAD_EN: TXD stays 1 and BUSY stays 0.
- Back-to-back: VALID held high with DIN=5'b00110, then 5'b11110 -> second START begins exactly 1 idle cycle after the first STOP ends; no word is lost or duplicated.
- Mid-frame reset: pull RST_N low in DATA bit 2 -> TXD=1 and BUSY=0 immediately; after release, a new word 5'b11110 is sent cleanly.
- BAUD_DIV=1: DIN=5'b00011 -> 7-cycle frame 0,0,0,0,1,1,1, with DIN_READY high again on cycle 8.

Source files
------------

// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer: re-checks even parity on {data,parity} and sends it as start(0), word MSB first, stop(1).
// TXD leaves idle 1 cycle after the accepting edge; DIN_READY only in IDLE, nothing is queued while a frame runs.
// Define PFS_DROP_BAD_EN to accept-and-discard words that fail parity instead of transmitting them.
module parity_frame_serializer #(
  parameter int DATA_W   = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [DATA_W:0] DIN,
  input  logic            DIN_VALID,
  output logic            DIN_READY,
  output logic            TXD,
  output logic            BUSY,
  output logic            PERR
);

  localparam int               WORD_W    = DATA_W + 1;
  localparam int               BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W);
  localparam logic [7:0]       BAUD_LAST = 8'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_baud_cnt, w_baud_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic [DATA_W:0]  r_shift, w_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_perr;
  logic             w_xfer;
  logic             w_bad;
  logic             w_drop;
  logic             w_baud_wrap;

  assign w_xfer      = DIN_VALID && (r_state == S_IDLE);
  assign w_bad       = ^DIN;
  assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);

`ifdef PFS_DROP_BAD_EN
  assign w_drop = w_bad;
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_perr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_perr     <= w_xfer && w_bad;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_shift_nxt = DIN;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          if (!w_drop) w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_wrap) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt = r_baud_cnt + 8'd1;
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit_cnt + 1'b1;
            w_shift_nxt = {r_shift[DATA_W-1:0], 1'b0};
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 8'd1;
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt = r_baud_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // TXD is decoded from the next state so the line itself comes straight off a flop.
  always_comb begin
    DIN_READY = (r_state == S_IDLE);
    BUSY      = (r_state != S_IDLE);
    TXD       = r_txd;
    PERR      = r_perr;
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[DATA_W];
      default: w_txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: two instances (BAUD_DIV=4 and BAUD_DIV=1) share all inputs.
module tb_parity_frame_serializer;
  localparam int DATA_W = 4;
`ifdef PFS_DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [DATA_W:0] DIN = '0;
  logic            DIN_VALID = 1'b0;
  logic            rdy0, txd0, busy0, perr0;
  logic            rdy1, txd1, busy1, perr1;
  int              n_tests = 0;
  int              n_fail = 0;

  always #5 CLK = ~CLK;

  parity_frame_serializer #(.DATA_W(DATA_W), .BAUD_DIV(4)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy0), .TXD(txd0), .BUSY(busy0), .PERR(perr0));

  parity_frame_serializer #(.DATA_W(DATA_W), .BAUD_DIV(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(rdy1), .TXD(txd1), .BUSY(busy1), .PERR(perr1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is a position counter over a (DATA_W+3)*B cycle line pattern.
  int              m_pos[2]  = '{-1, -1};
  logic [DATA_W:0] m_word[2] = '{'0, '0};
  logic            m_perr[2] = '{1'b0, 1'b0};

  function automatic int baud_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic line_bit(input logic [DATA_W:0] w, input int pos, input int b);
    int idx;
    idx = pos / b;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W + 1) return w[DATA_W + 1 - idx];
    return 1'b1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST_N) begin
        m_pos[k]  = -1;
        m_perr[k] = 1'b0;
      end else begin
        m_perr[k] = 1'b0;
        if (m_pos[k] < 0) begin
          if (DIN_VALID) begin
            m_perr[k] = ^DIN;
            if (!(DROP && (^DIN))) begin
              m_word[k] = DIN;
              m_pos[k]  = 0;
            end
          end
        end else begin
          m_pos[k]++;
          if (m_pos[k] == (DATA_W + 3) * baud_of(k)) m_pos[k] = -1;
        end
      end
    end
  end

  task automatic cmp_model(input int k, input logic txd, input logic busy, input logic rdy, input logic perr);
    logic exp_txd;
    exp_txd = (m_pos[k] < 0) ? 1'b1 : line_bit(m_word[k], m_pos[k], baud_of(k));
    chk($sformatf("model_txd%0d", k),  32'(txd),  32'(exp_txd));
    chk($sformatf("model_busy%0d", k), 32'(busy), 32'(m_pos[k] >= 0));
    chk($sformatf("model_rdy%0d", k),  32'(rdy),  32'(m_pos[k] < 0));
    chk($sformatf("model_perr%0d", k), 32'(perr), 32'(m_perr[k]));
  endtask

  always @(negedge CLK) begin
    cmp_model(0, txd0, busy0, rdy0, perr0);
    cmp_model(1, txd1, busy1, rdy1, perr1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after the accepting edge; samples the first cycle of each of the 7 line bits.
  task automatic capture(input bit sel, input int b, output logic [6:0] bits,
                         output int nbusy, output int nperr, output logic rdy_end);
    bits = '1; nbusy = 0; nperr = 0; rdy_end = 1'b0;
    for (int c = 0; c < 7 * b + 2; c++) begin
      if (c < 7 * b && (c % b) == 0) bits[6 - c / b] = sel ? txd1 : txd0;
      nbusy += int'(sel ? busy1 : busy0);
      nperr += int'(sel ? perr1 : perr0);
      if (c == 7 * b) rdy_end = sel ? rdy1 : rdy0;
      tick();
    end
  endtask

  task automatic send(input logic [DATA_W:0] w);
    DIN = w;
    DIN_VALID = 1'b1;
    tick();
    DIN_VALID = 1'b0;
  endtask

  logic [6:0] bits, f1, f2;
  int         nbusy, nperr;
  logic       rdy_end;

  initial begin
    repeat (3) tick();
    chk("rst_txd",  32'(txd0),  32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_rdy",  32'(rdy0),  32'd1);
    chk("rst_perr", 32'(perr0), 32'd0);
    RST_N = 1'b1;
    tick();
    chk("idle_txd",  32'(txd0),  32'd1);
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_rdy",  32'(rdy1),  32'd1);

    send(5'b10111);
    capture(1'b0, 4, bits, nbusy, nperr, rdy_end);
    chk("good_bits", 32'(bits), 32'b0101111);
    chk("good_busy", 32'(nbusy), 32'd28);
    chk("good_perr", 32'(nperr), 32'd0);
    chk("good_rdy",  32'(rdy_end), 32'd1);

    send(5'b10110);
    capture(1'b0, 4, bits, nbusy, nperr, rdy_end);
    chk("bad_bits", 32'(bits),  DROP ? 32'b1111111 : 32'b0101101);
    chk("bad_busy", 32'(nbusy), DROP ? 32'd0 : 32'd28);
    chk("bad_perr", 32'(nperr), 32'd1);

    DIN = 5'b00110;
    DIN_VALID = 1'b1;
    tick();
    DIN = 5'b11110;
    f1 = '1; f2 = '1;
    for (int c = 0; c < 60; c++) begin
      if (c < 28 && (c % 4) == 0) f1[6 - c / 4] = txd0;
      if (c >= 29 && c < 57 && ((c - 29) % 4) == 0) f2[6 - (c - 29) / 4] = txd0;
      if (c == 28) begin
        chk("b2b_gap_txd",  32'(txd0),  32'd1);
        chk("b2b_gap_busy", 32'(busy0), 32'd0);
        chk("b2b_gap_rdy",  32'(rdy0),  32'd1);
      end
      if (c == 29) begin
        chk("b2b_start2", 32'(txd0), 32'd0);
        DIN_VALID = 1'b0;
      end
      if (c == 57) chk("b2b_no_dup", 32'(busy0), 32'd0);
      tick();
    end
    chk("b2b_frame1", 32'(f1), 32'b0001101);
    chk("b2b_frame2", 32'(f2), 32'b0111101);

    send(5'b11000);
    repeat (13) tick();
    chk("mid_pre_txd",  32'(txd0),  32'd0);
    chk("mid_pre_busy", 32'(busy0), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_txd",  32'(txd0),  32'd1);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_rdy",  32'(rdy0),  32'd1);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    send(5'b11110);
    capture(1'b0, 4, bits, nbusy, nperr, rdy_end);
    chk("post_rst_bits", 32'(bits),  32'b0111101);
    chk("post_rst_busy", 32'(nbusy), 32'd28);

    send(5'b00011);
    capture(1'b1, 1, bits, nbusy, nperr, rdy_end);
    chk("b1_bits", 32'(bits),    32'b0000111);
    chk("b1_busy", 32'(nbusy),   32'd7);
    chk("b1_rdy8", 32'(rdy_end), 32'd1);
    chk("b1_perr", 32'(nperr),   32'd0);

    repeat (30) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
